// File: rtl/enc_disp_pkg.sv
// -----------------------------------------------------------------------------
// enc_disp_pkg
// Shared constants for the encoder/display block:
//   - active-low seven-segment glyphs {dp,g,f,e,d,c,b,a}, decimal point off
//   - digit-index encodings used by the scan multiplexer
//   - small type aliases for the bus signals
//   - BCD increment helper for the two-digit event counter
// -----------------------------------------------------------------------------
package enc_disp_pkg;

    typedef logic [1:0] code_t;
    typedef logic [7:0] seg_t;
    typedef logic [7:0] bcd2_t;

    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_BLANK = 8'hFF;

    // Scan position of each digit on the display.
    localparam logic [1:0] DIG_CODE  = 2'd0;
    localparam logic [1:0] DIG_BLANK = 2'd1;
    localparam logic [1:0] DIG_ONES  = 2'd2;
    localparam logic [1:0] DIG_TENS  = 2'd3;

    // Nibble value that the decoder renders as a blank digit.
    localparam logic [3:0] NIB_BLANK = 4'hF;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_disp_if.sv
// -----------------------------------------------------------------------------
// enc_disp_if
// Bundles the encoder input and display output signals of enc_disp.
//   code     : encoded key index from the 4-to-2 encoder
//   code_vld : encoder valid level (events are its rising edges)
//   seg      : active-low segment drive {dp,g,f,e,d,c,b,a}
//   an       : active-low, one-cold digit select
//   evt_cnt  : BCD event count {tens,ones}
// master drives code/code_vld (encoder side), slave is enc_disp.
// -----------------------------------------------------------------------------
interface enc_disp_if;
    import enc_disp_pkg::*;

    code_t      code;
    logic       code_vld;
    seg_t       seg;
    logic [3:0] an;
    bcd2_t      evt_cnt;

    modport master (
        output code,
        output code_vld,
        input  seg,
        input  an,
        input  evt_cnt
    );

    modport slave (
        input  code,
        input  code_vld,
        output seg,
        output an,
        output evt_cnt
    );

endinterface

// File: rtl/enc_disp_seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational BCD to seven-segment glyph decoder (active-low, dp off).
//   bcd_i : 4-bit digit value; anything above 9 renders blank
//   seg_o : glyph {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_dec
    import enc_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/enc_disp.sv
// -----------------------------------------------------------------------------
// enc_disp
// Captures an encoded key index on each rising edge of the encoder valid
// level, counts those events in two-digit BCD, and scans four multiplexed
// seven-segment digits:  digit0 = last key code, digit1 = blank,
// digit2 = event count ones, digit3 = event count tens.
//   SCAN_DIV : clk cycles spent on each digit (>= 2)
//   clk      : system clock, all state on the rising edge
//   rst      : synchronous, active-high reset
//   bus      : enc_disp_if.slave (code, code_vld in; seg, an, evt_cnt out)
// -----------------------------------------------------------------------------
module enc_disp
    import enc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic      clk,
    input  logic      rst,
    enc_disp_if.slave bus
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic             vld_q;
    code_t            code_q,    code_d;
    bcd2_t            evt_q,     evt_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [1:0]       idx_q,     idx_d;
    logic [3:0]       an_q,      an_d;
    seg_t             seg_q,     seg_d;

    logic             capture;
    logic             wrap;
    logic [3:0]       digit;

    // Capture path and scan prescaler are independent, so a capture and a
    // prescaler wrap in the same cycle both take effect.
    always_comb begin
        capture = bus.code_vld & ~vld_q;
        wrap    = (div_q == DIV_LAST);

        code_d  = capture ? bus.code        : code_q;
        evt_d   = capture ? bcd_inc(evt_q)  : evt_q;

        div_d   = wrap ? '0             : div_q + DIV_W'(1);
        idx_d   = wrap ? idx_q + 2'd1   : idx_q;
    end

    // Digit source for the current scan position; the display registers
    // sample this, so the glyph lags idx_q by one cycle.
    always_comb begin
        digit = NIB_BLANK;
        case (idx_q)
            DIG_CODE:  digit = {2'b00, code_q};
            DIG_BLANK: digit = NIB_BLANK;
            DIG_ONES:  digit = evt_q[3:0];
            DIG_TENS:  digit = evt_q[7:4];
            default:   digit = NIB_BLANK;
        endcase
    end

    seg7_dec u_seg7_dec (
        .bcd_i (digit),
        .seg_o (seg_d)
    );

    assign an_d = ~(4'b0001 << idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            code_q <= '0;
            evt_q  <= 8'h00;
            div_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            vld_q  <= bus.code_vld;
            code_q <= code_d;
            evt_q  <= evt_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.evt_cnt = evt_q;

endmodule

// File: tb/tb_enc_disp.sv
// -----------------------------------------------------------------------------
// tb_enc_disp
// Self-checking bench for enc_disp with SCAN_DIV = 4. Expected capture
// results are pushed to a scoreboard queue as each rising edge of code_vld
// is driven and popped when the DUT has taken the capture edge.
// -----------------------------------------------------------------------------
module tb_enc_disp;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] evt;
    } exp_t;

    localparam logic [7:0] G0     = 8'hC0;
    localparam logic [7:0] G1     = 8'hF9;
    localparam logic [7:0] G3     = 8'hB0;
    localparam logic [7:0] GBLANK = 8'hFF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    enc_disp_if bus ();

    enc_disp #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       sbq[$];
    int         modelCount = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] toBcd(input int c);
        return 8'(((c / 10) << 4) | (c % 10));
    endfunction

    task automatic doReset();
        rst = 1'b1;
        bus.code_vld = 1'b0;
        bus.code = 2'b00;
        step();
        rst = 1'b0;
        modelCount = 0;
        sbq.delete();
    endtask

    // Drives a rising edge of code_vld, records the expected capture result,
    // and steps through the capture edge.
    task automatic drivePulse(input logic [1:0] c);
        exp_t e;
        bus.code = c;
        bus.code_vld = 1'b1;
        modelCount = (modelCount + 1) % 100;
        e.code = c;
        e.evt  = toBcd(modelCount);
        sbq.push_back(e);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.code_vld = 1'b0;
        bus.code = 2'b00;
        step();
        step();
        checks++;
        if (bus.an !== 4'b1111) begin
            errors++; $display("[TB] FAIL reset_an got %b want 1111", bus.an);
        end
        checks++;
        if (bus.seg !== GBLANK) begin
            errors++; $display("[TB] FAIL reset_seg got %h want ff", bus.seg);
        end
        checks++;
        if (bus.evt_cnt !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_evt got %h want 00", bus.evt_cnt);
        end
    endtask

    task automatic test_scan();
        logic [3:0] anExp[4];
        logic [7:0] segExp[4];
        anExp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        segExp = '{G0, GBLANK, G0, G0};
        rst = 1'b0;
        modelCount = 0;
        step();
        for (int d = 0; d < 4; d++) begin
            if (d != 0) repeat (4) step();
            checks++;
            if (bus.an !== anExp[d]) begin
                errors++; $display("[TB] FAIL scan_an%0d got %b want %b", d, bus.an, anExp[d]);
            end
            checks++;
            if (bus.seg !== segExp[d]) begin
                errors++; $display("[TB] FAIL scan_seg%0d got %h want %h", d, bus.seg, segExp[d]);
            end
        end
    endtask

    task automatic test_single_pulse();
        exp_t e;
        bit found;
        doReset();
        drivePulse(2'b11);
        e = sbq.pop_front();
        checks++;
        if (bus.evt_cnt !== e.evt) begin
            errors++; $display("[TB] FAIL pulse_evt got %h want %h", bus.evt_cnt, e.evt);
        end
        checks++;
        if (dut.code_q !== e.code) begin
            errors++; $display("[TB] FAIL pulse_code got %0d want %0d", dut.code_q, e.code);
        end
        bus.code_vld = 1'b0;
        step();
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.an === 4'b1110) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL digit0_timeout got no an=1110 want an=1110 within 16 cycles");
        end else if (bus.seg !== G3) begin
            errors++; $display("[TB] FAIL digit0_seg got %h want %h", bus.seg, G3);
        end
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.an === 4'b1011) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL digit2_timeout got no an=1011 want an=1011 within 16 cycles");
        end else if (bus.seg !== G1) begin
            errors++; $display("[TB] FAIL digit2_seg got %h want %h", bus.seg, G1);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        doReset();
        drivePulse(2'b01);
        e = sbq.pop_front();
        checks++;
        if (bus.evt_cnt !== e.evt || dut.code_q !== e.code) begin
            errors++; $display("[TB] FAIL hold_first got evt=%h code=%0d want evt=%h code=%0d",
                               bus.evt_cnt, dut.code_q, e.evt, e.code);
        end
        for (int i = 1; i < 10; i++) begin
            bus.code = (i % 2 == 1) ? 2'b10 : 2'b01;
            step();
            checks++;
            if (bus.evt_cnt !== 8'h01 || dut.code_q !== 2'b01) begin
                errors++; $display("[TB] FAIL hold_cycle%0d got evt=%h code=%0d want evt=01 code=1",
                                   i, bus.evt_cnt, dut.code_q);
            end
        end
        bus.code_vld = 1'b0;
        step();
        checks++;
        if (bus.evt_cnt !== 8'h01) begin
            errors++; $display("[TB] FAIL hold_release got %h want 01", bus.evt_cnt);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        doReset();
        for (int p = 0; p < 100; p++) begin
            drivePulse(2'(p));
            e = sbq.pop_front();
            checks++;
            if (bus.evt_cnt !== e.evt || dut.code_q !== e.code) begin
                errors++; $display("[TB] FAIL wrap_pulse%0d got evt=%h code=%0d want evt=%h code=%0d",
                                   p, bus.evt_cnt, dut.code_q, e.evt, e.code);
            end
            bus.code_vld = 1'b0;
            step();
        end
        checks++;
        if (bus.evt_cnt !== 8'h00) begin
            errors++; $display("[TB] FAIL wrap_final got %h want 00", bus.evt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        doReset();
        for (int p = 0; p < 42; p++) begin
            drivePulse(2'b10);
            e = sbq.pop_front();
            bus.code_vld = 1'b0;
            step();
        end
        checks++;
        if (bus.evt_cnt !== 8'h42) begin
            errors++; $display("[TB] FAIL mid_count got %h want 42", bus.evt_cnt);
        end
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== GBLANK || bus.evt_cnt !== 8'h00) begin
            errors++; $display("[TB] FAIL mid_reset got an=%b seg=%h evt=%h want an=1111 seg=ff evt=00",
                               bus.an, bus.seg, bus.evt_cnt);
        end
        rst = 1'b0;
        modelCount = 0;
        step();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== G0) begin
            errors++; $display("[TB] FAIL mid_release got an=%b seg=%h want an=1110 seg=c0",
                               bus.an, bus.seg);
        end
    endtask

    task automatic test_coincident();
        exp_t e;
        doReset();
        repeat (3) step();
        drivePulse(2'b10);
        e = sbq.pop_front();
        checks++;
        if (bus.evt_cnt !== e.evt || dut.code_q !== e.code) begin
            errors++; $display("[TB] FAIL coinc_capture got evt=%h code=%0d want evt=%h code=%0d",
                               bus.evt_cnt, dut.code_q, e.evt, e.code);
        end
        bus.code_vld = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1101) begin
            errors++; $display("[TB] FAIL coinc_scan got %b want 1101", bus.an);
        end
    endtask

    task automatic test_release_capture();
        exp_t e;
        rst = 1'b1;
        bus.code = 2'b01;
        bus.code_vld = 1'b1;
        step();
        rst = 1'b0;
        sbq.delete();
        modelCount = 1;
        e.code = 2'b01;
        e.evt  = toBcd(modelCount);
        sbq.push_back(e);
        step();
        e = sbq.pop_front();
        checks++;
        if (bus.evt_cnt !== e.evt || dut.code_q !== e.code) begin
            errors++; $display("[TB] FAIL release_capture got evt=%h code=%0d want evt=%h code=%0d",
                               bus.evt_cnt, dut.code_q, e.evt, e.code);
        end
        bus.code_vld = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.code = 2'b00;
        bus.code_vld = 1'b0;
        test_reset();
        test_scan();
        test_single_pulse();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_coincident();
        test_release_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_disp.md
ENC_DISP -- requirements
Module: enc_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per display digit (legal range >= 2).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port code  input  2  encoded key index from the 4-to-2 encoder stage.
REQ-005 SHALL have port code_vld  input  1  encoder enable/valid level; capture events on its rising edge.
REQ-006 SHALL have port seg  output  8  segment drive {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port an  output  4  digit select, active-low, one-cold, registered.
REQ-008 SHALL have port evt_cnt  output  8  BCD event count {tens,ones}, registered.

Function
REQ-009 SHALL register code_vld into vld_q each cycle; a capture event occurs in a cycle where code_vld=1 and vld_q=0.
REQ-010 On a capture event, SHALL load code into code_q and increment evt_cnt by one in BCD, visible the next cycle (latency 1).
REQ-011 SHALL wrap evt_cnt from 8'h99 to 8'h00; ones digit 9 SHALL roll to 0 with tens increment.
REQ-012 While code_vld stays high, SHALL NOT re-capture; code changes without a new rising edge SHALL be ignored.
REQ-013 SHALL hold code_q and evt_cnt unchanged when no capture event occurs.
REQ-014 SHALL run prescaler div_q counting 0..SCAN_DIV-1; on div_q=SCAN_DIV-1 it wraps to 0 and digit index idx_q advances 0->1->2->3->0.
REQ-015 Each cycle (not in reset) SHALL register an = ~(4'b0001 << idx_q) and seg = glyph of digit idx_q (one-cycle lag behind idx_q).
REQ-016 Digit map: idx0 = code_q as decimal 0..3; idx1 = blank; idx2 = evt_cnt ones; idx3 = evt_cnt tens.
REQ-017 Glyphs (hex, dp off): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90, blank=FF.
REQ-018 A capture event and a prescaler wrap in the same cycle SHALL both take effect independently.
REQ-019 Displayed digits SHALL reflect updated code_q/evt_cnt no later than the next registered seg update for that digit.

Reset
REQ-020 When rst=1 at a clock edge, SHALL set vld_q=0, code_q=0, evt_cnt=8'h00, div_q=0, idx_q=0, an=4'b1111, seg=8'hFF.
REQ-021 Reset asserted mid-operation SHALL take priority over capture and scan updates in that cycle.
REQ-022 First cycle after rst release SHALL drive an=4'b1110, seg=8'hC0.
REQ-023 If code_vld is high when rst releases, SHALL treat it as a rising edge (vld_q=0) and capture.

Structure
REQ-024 Glyph constants (SEG_0..SEG_9, SEG_BLANK) and digit-index encodings SHALL live in shared package enc_disp_pkg.
REQ-025 BCD-to-glyph mapping SHALL be a combinational sub-module seg7_dec (4-bit in, 8-bit out, values >9 -> SEG_BLANK).
REQ-026 Implementation SHALL be fully synchronous with no latches and no derived clocks.

Verification (bench uses SCAN_DIV=4)
REQ-027 Reset release, code_vld=0 -> cycle 1: an=1110 seg=C0; after 4 cycles an=1101 seg=FF; next 4 an=1011 seg=C0; next 4 an=0111 seg=C0.
REQ-028 code=2'b11, pulse code_vld 1 cycle -> next cycle code_q=3, evt_cnt=8'h01; digit0 shows B0, digit2 shows F9.
REQ-029 Hold code_vld high 10 cycles while code toggles 01/10 -> evt_cnt increments once only, code_q = value at rising edge.
REQ-030 Apply 100 pulses -> evt_cnt passes 8'h09->8'h10 and 8'h99->8'h00; final evt_cnt=8'h00.
REQ-031 Assert rst for one cycle mid-scan with evt_cnt=8'h42 -> next cycle an=1111 seg=FF evt_cnt=8'h00; following cycle an=1110 seg=C0.
REQ-032 Rising edge of code_vld coincident with prescaler wrap -> idx advances and evt_cnt increments in the same cycle.
